ram_dump_unit: RTL and testbench
================================

// Module: ram_dump_unit
// PURPOSE
//  Debug read-back engine for the RISC_SPM 256x8 program/data RAM: reads memory[start_addr..end_addr]
//  through the RAM read port and streams each byte, tagged with its address, over a valid/ready port.
//  Counterpart of the program loader/backdoor writer; lets benches and debug hosts check RAM after a run.
//  Sits beside the RAM; owns the RAM read port only while busy=1 (CPU held in reset or stalled).
// PARAMETERS
//  ADDR_W      8  RAM address width (memory depth 2**ADDR_W)
//  DATA_W      8  RAM word width
//  FIFO_DEPTH  2  output buffer entries (>=2, power of 2); hides the 1-cycle RAM read latency
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse; latches start_addr/end_addr; ignored while busy=1
//  abort       in   1       synchronous abort of a running dump
//  start_addr  in   ADDR_W  first address read
//  end_addr    in   ADDR_W  last address read (inclusive)
//  mem_rd      out  1       RAM read strobe
//  mem_addr    out  ADDR_W  RAM read address
//  mem_data    in   DATA_W  RAM read data, valid the cycle after mem_rd=1
//  dout        out  DATA_W  streamed byte
//  dout_addr   out  ADDR_W  address of dout
//  dout_valid  out  1       dout/dout_addr valid
//  dout_ready  in   1       sink accepts; transfer when dout_valid&dout_ready
//  busy        out  1       high from cycle after accepted start until DONE
//  done        out  1       1-cycle pulse after last byte transferred
// BEHAVIOUR
//  Reset: state=IDLE; mem_rd, mem_addr, dout, dout_addr, dout_valid, busy, done all 0; FIFO empty.
//  rst wins over every other input; rst mid-dump discards in-flight read and FIFO contents.
//  FSM: IDLE -start-> RUN; RUN -last read issued-> DRAIN; DRAIN -FIFO empty & no read in flight-> DONE;
//   DONE -> IDLE (done=1 for exactly that cycle). abort in RUN/DRAIN -> IDLE next cycle, FIFO flushed,
//   no done pulse; abort in IDLE/DONE ignored. abort and start same cycle in IDLE: start taken.
//  Length: n = (end_addr - start_addr) mod 2**ADDR_W + 1; start==end -> 1 byte; end<start wraps
//   through 2**ADDR_W-1 -> 0 (e.g. start=FE, end=01 -> FE,FF,00,01). 256-byte dump: start=00,end=FF.
//  Issue rule: mem_rd=1 in RUN only when (FIFO occupancy + read in flight) < FIFO_DEPTH, counting a
//   same-cycle pop as freeing an entry; mem_addr increments mod 2**ADDR_W after each issued read.
//  Capture: cycle after mem_rd=1, mem_data and its address are pushed; push never hits a full FIFO.
//  Output: dout_valid = FIFO not empty; dout/dout_addr = FIFO head, stable while valid&!ready.
//   Bytes emitted strictly in address order, each exactly once. Simultaneous push+pop allowed.
//  Throughput: with dout_ready held 1, one byte per cycle; first dout_valid 2 cycles after start.
//  mem_addr and mem_rd are 0 when not in RUN.
// STRUCTURE
//  risc_spm_defs.vh (shared include): FSM state encodings S_IDLE/S_RUN/S_DRAIN/S_DONE, ADDR_W/DATA_W defaults.
//  Sub-module dump_fifo: synchronous FIFO, width DATA_W+ADDR_W, depth FIFO_DEPTH, push/pop/full/empty/count,
//   synchronous active-high clear (driven by rst | abort-taken).
//  Top: FSM, address and remaining-count registers, read-in-flight flag, issue logic.
// TESTING
//  1 RAM[0..4]=00,50,03,40,80; start 0..4, ready=1 -> 5 beats addr 0..4 data 00,50,03,40,80, done pulse, busy low.
//  2 Same dump, dout_ready toggled 1010... and random stalls -> identical sequence, no drop/dup, head stable under stall.
//  3 start=FE,end=01 with RAM[FE]=AA,[FF]=BB,[00]=CC,[01]=DD -> beats AA,BB,CC,DD in that order, addr FE,FF,00,01.
//  4 start=07,end=07 -> exactly one beat (addr 07); start=00,end=FF -> 256 beats, 1 per cycle after 2-cycle latency.
//  5 abort after 3rd beat, ready=0 -> dout_valid=0 next cycle, no done, busy=0; new start 10..11 runs cleanly.
//  6 rst asserted mid-RUN with FIFO full -> next cycle all outputs 0, IDLE; start pulse while busy ignored.

Source files
------------

// File: rtl/ram_dump_unit_pkg.sv
// Shared definitions for the RAM dump engine: FSM state encoding and default widths.
package ram_dump_unit_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/ram_dump_unit_fifo.sv
// Small synchronous FIFO holding {address, data} beats between the RAM read port and the stream port.
module ram_dump_unit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data only; a clear just resets the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/ram_dump_unit.sv
// Debug read-back engine: reads RAM[start..end] (wrapping) through the RAM read port and
// streams each byte with its address over a valid/ready port.
module ram_dump_unit
    import ram_dump_unit_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_dout,
    output logic [ADDR_W-1:0] o_dout_addr,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_busy,
    output logic              o_done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_W-1:0]         r_addr;
    logic [ADDR_W-1:0]         r_rd_addr;
    logic [ADDR_W:0]           r_remain;
    logic                      r_inflight;
    logic                      w_issue;
    logic                      w_pop;
    logic                      w_empty;
    logic                      w_clear;
    logic                      w_abort_take;
    logic                      w_start_take;
    logic [CNT_W-1:0]          w_count;
    logic [CNT_W:0]            w_occ;
    logic [ADDR_W+DATA_W-1:0]  w_head;

    assign w_start_take = (r_state == S_IDLE) && i_start;
    assign w_abort_take = i_abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_pop        = !w_empty && i_dout_ready;
    assign w_clear      = i_rst || w_abort_take;

    // Entries committed to the FIFO after this cycle; a same-cycle pop frees a slot.
    assign w_occ = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_issue = (w_occ < (CNT_W+1)'(FIFO_DEPTH));
                    if (w_issue && (r_remain == (ADDR_W+1)'(1))) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_empty && !r_inflight) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
            r_addr     <= '0;
            r_remain   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_start_take) begin
                r_addr   <= i_start_addr;
                r_remain <= {1'b0, i_end_addr - i_start_addr} + (ADDR_W+1)'(1);
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_remain <= r_remain - (ADDR_W+1)'(1);
            end
        end
    end

    // Address tag travels with the read so the returning byte is pushed already labelled.
    always_ff @(posedge i_clk) begin
        if (w_issue) r_rd_addr <= r_addr;
    end

    ram_dump_unit_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_clear (w_clear),
        .i_push  (r_inflight),
        .i_data  ({r_rd_addr, i_mem_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign o_mem_rd     = w_issue;
    assign o_mem_addr   = (r_state == S_RUN) ? r_addr : '0;
    assign o_dout_valid = !w_empty;
    assign o_dout       = w_empty ? '0 : w_head[DATA_W-1:0];
    assign o_dout_addr  = w_empty ? '0 : w_head[ADDR_W+DATA_W-1:DATA_W];
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
endmodule

// File: tb/tb_ram_dump_unit.sv
// Scoreboard bench for ram_dump_unit: expected beats queued at start, checked by a negedge monitor.
module tb_ram_dump_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic [7:0] end_addr = 8'h00;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] dout;
    logic [7:0] dout_addr;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic       busy;
    logic       done;

    logic [7:0]  ram [256];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;
    int          mode = 0;

    ram_dump_unit #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .o_mem_rd     (mem_rd),
        .o_mem_addr   (mem_addr),
        .i_mem_data   (mem_data),
        .o_dout       (dout),
        .o_dout_addr  (dout_addr),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink readiness pattern: 0 always ready, 1 toggle, 2 random, 3 never ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = !dout_ready;
                2:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks head stability under stall.
    initial begin
        logic        hold;
        logic [15:0] held;
        logic [15:0] got;
        logic [15:0] exp;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {dout_addr, dout};
            if (done) done_cnt++;
            if (hold && dout_valid) check("head_stable", 32'(got), 32'(held));
            if (dout_valid && dout_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", 32'(got), 32'(exp));
                end
            end
            hold = dout_valid && !dout_ready;
            held = got;
        end
    end

    task automatic expect_range(input logic [7:0] s, input logic [7:0] e);
        logic [7:0] d;
        logic [7:0] a;
        int n;
        d = e - s;
        n = int'(d) + 1;
        for (int i = 0; i < n; i++) begin
            a = s + 8'(i);
            exp_q.push_back({a, ram[a]});
        end
    endtask

    task automatic pulse_start(input logic [7:0] s, input logic [7:0] e, input bit ab);
        @(posedge clk);
        #1;
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        abort      = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_dump(input logic [7:0] s, input logic [7:0] e, input bit chk_lat,
                            input bit inject, input bit ab);
        logic [7:0] d;
        int n;
        int cyc;
        int first;
        d = e - s;
        n = int'(d) + 1;
        expect_range(s, e);
        pulse_start(s, e, ab);
        check("busy_after_start", 32'(busy), 32'd1);
        if (inject) begin
            start_addr = s + 8'h40;
            end_addr   = s + 8'h41;
            start      = 1'b1;
        end
        cyc   = 0;
        first = -1;
        while (!done && cyc < 2000) begin
            if (dout_valid && first < 0) first = cyc;
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
        end
        check("done_seen", 32'(cyc < 2000), 32'd1);
        if (chk_lat) begin
            check("first_valid_latency", 32'(first), 32'd2);
            check("dump_cycles", 32'(cyc), 32'(n + 3));
        end
        check("all_beats_out", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_low_after", 32'(busy), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_rd"},    32'(mem_rd),     32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),   32'd0);
        check({tag, "_dout"},      32'(dout),       32'd0);
        check({tag, "_dout_addr"}, 32'(dout_addr),  32'd0);
        check({tag, "_valid"},     32'(dout_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_done"},      32'(done),       32'd0);
    endtask

    initial begin
        int b0;
        int d0;
        int cyc;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[0] = 8'h00; ram[1] = 8'h50; ram[2] = 8'h03; ram[3] = 8'h40; ram[4] = 8'h80;
        ram[8'hFE] = 8'hAA; ram[8'hFF] = 8'hBB;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Basic dump, full-rate sink.
        mode = 0;
        run_dump(8'h00, 8'h04, 1, 0, 0);

        // Same dump under toggling and random stalls.
        mode = 1;
        run_dump(8'h00, 8'h04, 0, 0, 0);
        mode = 2;
        run_dump(8'h00, 8'h04, 0, 0, 0);

        // Wrapping dump, with abort in the same cycle as start (start wins).
        ram[8'h00] = 8'hCC; ram[8'h01] = 8'hDD;
        mode = 0;
        run_dump(8'hFE, 8'h01, 1, 0, 1);

        // Single byte and full-memory dumps; a start pulse mid-dump must be ignored.
        run_dump(8'h07, 8'h07, 1, 0, 0);
        run_dump(8'h00, 8'hFF, 1, 0, 0);
        run_dump(8'h30, 8'h37, 1, 1, 0);

        // Abort after the third beat with the sink stalled.
        b0 = beat_cnt;
        expect_range(8'h20, 8'h2F);
        pulse_start(8'h20, 8'h2F, 0);
        cyc = 0;
        while ((beat_cnt - b0) < 3 && cyc < 100) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("abort_reach_3", 32'(cyc < 100), 32'd1);
        mode       = 3;
        dout_ready = 1'b0;
        abort      = 1'b1;
        d0         = done_cnt;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_busy",  32'(busy),       32'd0);
        check("abort_mem_rd", 32'(mem_rd),    32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_beats",   32'(beat_cnt - b0), 32'd3);
        mode = 0;
        run_dump(8'h10, 8'h11, 1, 0, 0);

        // Reset mid-dump with the FIFO full.
        mode       = 3;
        dout_ready = 1'b0;
        pulse_start(8'h40, 8'h4F, 0);
        repeat (5) @(posedge clk);
        #1;
        check("full_valid", 32'(dout_valid), 32'd1);
        check("full_head_addr", 32'(dout_addr), 32'h40);
        check("full_no_issue", 32'(mem_rd), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("mid_reset");
        rst  = 1'b0;
        mode = 0;
        run_dump(8'h50, 8'h52, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
